// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the multiply operation encoding.
//   OPCODE_OP      : major opcode of register-register ALU ops
//   FUNCT7_MULDIV  : funct7 value selecting the M extension
//   mul_op_e       : funct3 encodings of the four multiply flavours
package rv32_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_op_e;

endpackage

// File: rtl/rv32m_mul_pp.sv
// 17x17 signed partial-product multiplier, purely combinational.
//   a, b : 17-bit two's-complement operands
//   p    : 34-bit signed product (never overflows)
module rv32m_mul_pp (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [33:0] p
);

    assign p = 34'($signed(a)) * 34'($signed(b));

endmodule

// File: rtl/rv32m_mul_pipe.sv
// Pipelined RV32M multiply unit (MUL, MULH, MULHSU, MULHU).
// Decodes the instruction fields itself, accepts one op per clock, no stalls.
//   clk_i       : clock, rising edge
//   rst_ni      : synchronous active-low reset, clears every pipeline register
//   mult_in1_i  : rs1 operand
//   mult_in2_i  : rs2 operand
//   opcode_i    : instruction opcode
//   funct7_i    : instruction funct7
//   funct3_i    : instruction funct3, selects the operation
//   result_o    : selected product half of the op issued NUM_STAGE clocks earlier, 0 when not valid
//   valid_o     : high exactly when result_o holds a multiply result
// NUM_STAGE (1..4) is the number of register levels from operand capture to outputs.
module rv32m_mul_pipe #(
    parameter int NUM_STAGE = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] mult_in1_i,
    input  logic [31:0] mult_in2_i,
    input  logic [6:0]  opcode_i,
    input  logic [6:0]  funct7_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o,
    output logic        valid_o
);

    import rv32_pkg::*;

    // Register levels after the partial-product stage (at least one, the output register).
    localparam int OUT_LVL = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    logic        is_mul;
    mul_op_e     op;
    logic        a_sgn;
    logic        b_sgn;
    logic [32:0] a_ext;
    logic [32:0] b_ext;
    logic [33:0] pp_ll, pp_lh, pp_hl, pp_hh;

    assign is_mul = (opcode_i == OPCODE_OP) && (funct7_i == FUNCT7_MULDIV) && !funct3_i[2];
    assign op     = mul_op_e'({1'b0, funct3_i[1:0]});
    assign a_sgn  = (op == MULH) || (op == MULHSU);
    assign b_sgn  = (op == MULH);
    assign a_ext  = {a_sgn & mult_in1_i[31], mult_in1_i};
    assign b_ext  = {b_sgn & mult_in2_i[31], mult_in2_i};

    // Low halves are zero-extended to 17 bits, high halves keep the 33-bit sign.
    rv32m_mul_pp u_pp_ll (.a({1'b0, a_ext[15:0]}), .b({1'b0, b_ext[15:0]}), .p(pp_ll));
    rv32m_mul_pp u_pp_lh (.a({1'b0, a_ext[15:0]}), .b(b_ext[32:16]),        .p(pp_lh));
    rv32m_mul_pp u_pp_hl (.a(a_ext[32:16]),        .b({1'b0, b_ext[15:0]}), .p(pp_hl));
    rv32m_mul_pp u_pp_hh (.a(a_ext[32:16]),        .b(b_ext[32:16]),        .p(pp_hh));

    logic [33:0] pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
    mul_op_e     op_s;
    logic        vld_s;

    if (NUM_STAGE == 1) begin : g_comb
        assign pp_ll_s = pp_ll;
        assign pp_lh_s = pp_lh;
        assign pp_hl_s = pp_hl;
        assign pp_hh_s = pp_hh;
        assign op_s    = op;
        assign vld_s   = is_mul;
    end else begin : g_stage1
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                pp_ll_s <= '0;
                pp_lh_s <= '0;
                pp_hl_s <= '0;
                pp_hh_s <= '0;
                op_s    <= MUL;
                vld_s   <= 1'b0;
            end else begin
                pp_ll_s <= pp_ll;
                pp_lh_s <= pp_lh;
                pp_hl_s <= pp_hl;
                pp_hh_s <= pp_hh;
                op_s    <= op;
                vld_s   <= is_mul;
            end
        end
    end

    logic [63:0] prod;
    logic [31:0] res_d;
    logic        vld_d;

    // Sum partials modulo 2^64; the 33x33 product always fits in 64 bits once truncated.
    always_comb begin
        prod = ({{30{pp_hh_s[33]}}, pp_hh_s} << 32)
             + ({{30{pp_lh_s[33]}}, pp_lh_s} << 16)
             + ({{30{pp_hl_s[33]}}, pp_hl_s} << 16)
             +  {{30{pp_ll_s[33]}}, pp_ll_s};
        res_d = 32'h0;
        vld_d = vld_s;
        if (vld_s) begin
            res_d = (op_s == MUL) ? prod[31:0] : prod[63:32];
        end
    end

    for (genvar i = 0; i < OUT_LVL; i++) begin : g_out
        logic [31:0] res_in;
        logic        vld_in;
        logic [31:0] res_r;
        logic        vld_r;

        if (i == 0) begin : g_first
            assign res_in = res_d;
            assign vld_in = vld_d;
        end else begin : g_next
            assign res_in = g_out[i-1].res_r;
            assign vld_in = g_out[i-1].vld_r;
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                res_r <= 32'h0;
                vld_r <= 1'b0;
            end else begin
                res_r <= res_in;
                vld_r <= vld_in;
            end
        end
    end

    assign result_o = g_out[OUT_LVL-1].res_r;
    assign valid_o  = g_out[OUT_LVL-1].vld_r;

endmodule

// File: tb/tb_rv32m_mul_pipe.sv
module tb_rv32m_mul_pipe;

    localparam int HMAX = 2048;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] r1, r2, r4;
    logic        v1, v2, v4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic        hist_rst [HMAX];
    logic        hist_v   [HMAX];
    logic [31:0] hist_r   [HMAX];
    logic        obs_v1 [HMAX];
    logic        obs_v2 [HMAX];
    logic        obs_v4 [HMAX];
    logic [31:0] obs_r1 [HMAX];
    logic [31:0] obs_r2 [HMAX];
    logic [31:0] obs_r4 [HMAX];

    rv32m_mul_pipe #(.NUM_STAGE(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mult_in1_i(a), .mult_in2_i(b),
        .opcode_i(opc), .funct7_i(f7), .funct3_i(f3), .result_o(r1), .valid_o(v1));
    rv32m_mul_pipe #(.NUM_STAGE(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .mult_in1_i(a), .mult_in2_i(b),
        .opcode_i(opc), .funct7_i(f7), .funct3_i(f3), .result_o(r2), .valid_o(v2));
    rv32m_mul_pipe #(.NUM_STAGE(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .mult_in1_i(a), .mult_in2_i(b),
        .opcode_i(opc), .funct7_i(f7), .funct3_i(f3), .result_o(r4), .valid_o(v4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_is_mul(logic [6:0] o, logic [6:0] s7, logic [2:0] s3);
        return (o == 7'b0110011) && (s7 == 7'h01) && (s3[2] == 1'b0);
    endfunction

    // Plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model_res(logic [1:0] sel, logic [31:0] x, logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (sel)
            2'd0:    p = ux * uy;
            2'd1:    p = sx * sy;
            2'd2:    p = longint'(sx * longint'(uy));
            default: p = ux * uy;
        endcase
        return (sel == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Expected output after edge m for a pipe of depth n: the op seen at edge m-n+1,
    // unless a reset edge lies anywhere in [m-n+1, m].
    task automatic exp_for(input int m, input int n, output logic ev, output logic [31:0] er);
        int first;
        ev = 1'b0;
        er = 32'h0;
        first = m - n + 1;
        if (first < 1) return;
        for (int j = first; j <= m; j++) begin
            if (hist_rst[j]) return;
        end
        ev = hist_v[first];
        er = ev ? hist_r[first] : 32'h0;
    endtask

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got valid=%0b result=%08h, expected valid=%0b result=%08h",
                     name, act[32], act[31:0], req[32], req[31:0]);
        end
    endtask

    task automatic tick();
        logic        ev;
        logic [31:0] er;
        @(posedge clk);
        cyc++;
        hist_rst[cyc] = !rst_n;
        hist_v[cyc]   = model_is_mul(opc, f7, f3);
        hist_r[cyc]   = model_res(f3[1:0], a, b);
        @(negedge clk);
        obs_v1[cyc] = v1; obs_r1[cyc] = r1;
        obs_v2[cyc] = v2; obs_r2[cyc] = r2;
        obs_v4[cyc] = v4; obs_r4[cyc] = r4;
        exp_for(cyc, 1, ev, er);
        chk($sformatf("model_n1_cyc%0d", cyc), {v1, r1}, {ev, er});
        exp_for(cyc, 2, ev, er);
        chk($sformatf("model_n2_cyc%0d", cyc), {v2, r2}, {ev, er});
        exp_for(cyc, 4, ev, er);
        chk($sformatf("model_n4_cyc%0d", cyc), {v4, r4}, {ev, er});
    endtask

    task automatic drive(input logic [6:0] o, input logic [6:0] s7, input logic [2:0] s3,
                         input logic [31:0] x, input logic [31:0] y);
        opc = o; f7 = s7; f3 = s3; a = x; b = y;
    endtask

    task automatic idle();
        drive(7'h00, 7'h00, 3'b000, 32'h0, 32'h0);
    endtask

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        ev;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          c0;
        logic        any_v;
        logic [31:0] ra, rb;

        vecs[0] = '{"mul_7x6",      7'b0110011, 7'h01, 3'b000, 32'd7,         32'd6,         1'b1, 32'd42};
        vecs[1] = '{"mulh_min_sq",  7'b0110011, 7'h01, 3'b001, 32'h80000000,  32'h80000000,  1'b1, 32'h40000000};
        vecs[2] = '{"mulh_m1_sq",   7'b0110011, 7'h01, 3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'h00000000};
        vecs[3] = '{"mulhsu_ones",  7'b0110011, 7'h01, 3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF};
        vecs[4] = '{"mulhu_ones",   7'b0110011, 7'h01, 3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFE};
        vecs[5] = '{"div_funct3",   7'b0110011, 7'h01, 3'b100, 32'd7,         32'd6,         1'b0, 32'h0};
        vecs[6] = '{"opimm_opcode", 7'b0010011, 7'h01, 3'b000, 32'd7,         32'd6,         1'b0, 32'h0};

        // Reset held for three clocks, then 20 idle clocks.
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        chk("reset_n1", {v1, r1}, 33'h0);
        chk("reset_n2", {v2, r2}, 33'h0);
        chk("reset_n4", {v4, r4}, 33'h0);
        rst_n = 1'b1;
        any_v = 1'b0;
        repeat (20) begin
            tick();
            any_v = any_v | v1 | v2 | v4;
        end
        chk("idle_after_reset", {any_v, 32'h0}, 33'h0);

        // Isolated vectors: expected value two clocks after issue, valid for one cycle only.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].opc, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b);
            tick();
            c0 = cyc;
            idle();
            repeat (5) tick();
            chk({vecs[i].name, "_n2"}, {obs_v2[c0+1], obs_r2[c0+1]}, {vecs[i].ev, vecs[i].er});
            chk({vecs[i].name, "_n2_early"}, {obs_v2[c0], 32'h0}, 33'h0);
            chk({vecs[i].name, "_n2_pulse"}, {obs_v2[c0+2], 32'h0}, 33'h0);
            if (i == 0) begin
                chk("mul_7x6_n1", {obs_v1[c0], obs_r1[c0]}, {1'b1, 32'd42});
                chk("mul_7x6_n1_pulse", {obs_v1[c0+1], 32'h0}, 33'h0);
                chk("mul_7x6_n4", {obs_v4[c0+3], obs_r4[c0+3]}, {1'b1, 32'd42});
                chk("mul_7x6_n4_early", {obs_v4[c0+2], 32'h0}, 33'h0);
                chk("mul_7x6_n4_pulse", {obs_v4[c0+4], 32'h0}, 33'h0);
            end
        end

        // Five back-to-back MULHU with operands in +/-1e7.
        c0 = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            ra = 32'($urandom_range(20000000, 0)) - 32'd10000000;
            rb = 32'($urandom_range(20000000, 0)) - 32'd10000000;
            drive(7'b0110011, 7'h01, 3'b011, ra, rb);
            tick();
        end
        idle();
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mulhu_b2b_%0d", i), {obs_v2[c0+i+1], obs_r2[c0+i+1]},
                {1'b1, hist_r[c0+i]});
        end
        chk("mulhu_b2b_end", {obs_v2[c0+6], 32'h0}, 33'h0);

        // Two ops in flight when reset hits: neither may come out of the 2- or 4-deep pipes.
        drive(7'b0110011, 7'h01, 3'b000, 32'd1234, 32'd5678);
        tick();
        c0 = cyc;
        drive(7'b0110011, 7'h01, 3'b001, 32'h7FFFFFFF, 32'h00000003);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        any_v = 1'b0;
        repeat (6) tick();
        for (int j = c0; j <= c0 + 6; j++) any_v = any_v | obs_v2[j] | obs_v4[j];
        chk("flush_in_flight", {any_v, 32'h0}, 33'h0);

        // First op after reset still emits normally.
        drive(7'b0110011, 7'h01, 3'b000, 32'd9, 32'd11);
        tick();
        c0 = cyc;
        idle();
        repeat (4) tick();
        chk("post_reset_mul_n2", {obs_v2[c0+1], obs_r2[c0+1]}, {1'b1, 32'd99});

        // Random traffic, mostly multiplies, some other encodings and occasional resets.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(9, 0) < 7)
                drive(7'b0110011, 7'h01, 3'($urandom_range(3, 0)), ra, rb);
            else
                drive(7'($urandom), ($urandom_range(1, 0) == 0) ? 7'h01 : 7'($urandom),
                      3'($urandom), ra, rb);
            rst_n = ($urandom_range(39, 0) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
